// File: rtl/eth_tx_clk_ctrl_if.sv
// Request/status bundle between MAC/management logic and the TX clock controller.
// Requester -> controller: link_up, speed_req, speed_req_valid.
// Controller -> requester/PHY: speed_ack, speed_err, cur_speed, gmii_sel, tx_clk, tx_clk_rise, busy.
interface eth_tx_clk_ctrl_if;
   logic       link_up;
   logic [1:0] speed_req;
   logic       speed_req_valid;
   logic       speed_ack;
   logic       speed_err;
   logic [1:0] cur_speed;
   logic       gmii_sel;
   logic       tx_clk;
   logic       tx_clk_rise;
   logic       busy;

   modport master (
      output link_up, speed_req, speed_req_valid,
      input  speed_ack, speed_err, cur_speed, gmii_sel, tx_clk, tx_clk_rise, busy
   );

   modport slave (
      input  link_up, speed_req, speed_req_valid,
      output speed_ack, speed_err, cur_speed, gmii_sel, tx_clk, tx_clk_rise, busy
   );
endinterface

// File: rtl/eth_tx_clk_ctrl.sv
// Speed-aware Ethernet TX clock generator with glitch-free 10M/100M/1000M switching.
// Latency: same-speed/illegal requests ack 1 cycle after sampling; changes ack after drain + hold + load.
// Backpressure: speed_req_valid is a level held until speed_ack; requests are ignored while busy.
// Ports: rx_clk125/reset_n plain; bus (slave modport) carries link_up, speed request handshake,
//        and the generated tx_clk/tx_clk_rise/gmii_sel plus status (cur_speed, busy).
module eth_tx_clk_ctrl #(
   parameter int unsigned DIV_10M     = 50,
   parameter int unsigned HIGH_10M    = 25,
   parameter int unsigned DIV_100M    = 5,
   parameter int unsigned HIGH_100M   = 2,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter logic [1:0]  RESET_SPEED = 2'b00
) (
   input  logic             rx_clk125,
   input  logic             reset_n,
   eth_tx_clk_ctrl_if.slave bus
);
   localparam logic [1:0] SPD_10M  = 2'b00;
   localparam logic [1:0] SPD_100M = 2'b01;
   localparam logic [1:0] SPD_1G   = 2'b10;
   localparam logic [1:0] SPD_ILL  = 2'b11;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HOLD, ST_LOAD} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [5:0] r_cnt;
   logic [5:0] r_hold;
   logic [1:0] r_cur;
   logic [1:0] r_tgt;
   logic       r_tx_clk;
   logic       r_rise;
   logic       r_ack;
   logic       r_err;
   logic       r_gmii;

   logic [5:0] w_div_m1;
   logic [5:0] w_high;
   logic       w_is_1g;
   logic       w_clk_en;
   logic       w_accept;
   logic       w_ack_nxt;
   logic       w_err_nxt;

   // Divider only runs while the link is up and the FSM is not forcing the clock low.
   always_comb begin
      w_is_1g  = (r_cur == SPD_1G);
      w_div_m1 = (r_cur == SPD_100M) ? 6'(DIV_100M - 1) : 6'(DIV_10M - 1);
      w_high   = (r_cur == SPD_100M) ? 6'(HIGH_100M)    : 6'(HIGH_10M);
      w_clk_en = bus.link_up && !w_is_1g && (r_state == ST_RUN || r_state == ST_DRAIN);
      // Blocking on r_ack keeps the ack a single pulse for a requester still holding valid.
      w_accept = (r_state == ST_RUN) && bus.speed_req_valid && !r_ack;
   end

   always_ff @(posedge rx_clk125 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_accept) begin
               if (bus.speed_req == SPD_ILL) begin
                  w_ack_nxt = 1'b1;
                  w_err_nxt = 1'b1;
               end else if (bus.speed_req == r_cur) begin
                  w_ack_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Leave only at the last low cycle so a high phase is never cut short.
            if (w_is_1g || !bus.link_up || (!r_tx_clk && r_cnt == w_div_m1)) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (r_hold == 6'(HOLD_CYCLES - 1)) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_state_nxt = ST_RUN;
            w_ack_nxt   = 1'b1;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge rx_clk125 or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_hold   <= '0;
         r_cur    <= RESET_SPEED;
         r_tgt    <= RESET_SPEED;
         r_tx_clk <= 1'b0;
         r_rise   <= 1'b0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_gmii   <= (RESET_SPEED == SPD_1G);
      end else begin
         r_ack <= w_ack_nxt;
         r_err <= w_err_nxt;
         if (r_state == ST_RUN && w_state_nxt == ST_DRAIN) begin
            r_tgt <= bus.speed_req;
         end
         // Counter parks at 0 when disabled, so restart always begins with a full high phase.
         if (w_clk_en) begin
            r_cnt <= (r_cnt == w_div_m1) ? 6'd0 : r_cnt + 6'd1;
         end else begin
            r_cnt <= 6'd0;
         end
         r_tx_clk <= w_clk_en && (r_cnt < w_high);
         r_rise   <= (w_clk_en && r_cnt == 6'd0) ||
                     (bus.link_up && w_is_1g && r_state == ST_RUN);
         r_hold   <= (r_state == ST_HOLD) ? r_hold + 6'd1 : 6'd0;
         // gmii_sel drops on HOLD entry (tx_clk already low) and is set only on LOAD.
         if (r_state == ST_LOAD) begin
            r_cur  <= r_tgt;
            r_gmii <= (r_tgt == SPD_1G);
         end else if (w_state_nxt == ST_HOLD) begin
            r_gmii <= 1'b0;
         end
      end
   end

   assign bus.speed_ack   = r_ack;
   assign bus.speed_err   = r_err;
   assign bus.cur_speed   = r_cur;
   assign bus.gmii_sel    = r_gmii;
   assign bus.tx_clk      = r_tx_clk;
   assign bus.tx_clk_rise = r_rise;
   assign bus.busy        = (r_state != ST_RUN);
endmodule

// File: tb/tb_eth_tx_clk_ctrl.sv
// Directed bench for eth_tx_clk_ctrl: reset, 10M/100M/1000M generation, speed switching,
// illegal/same-speed requests, link loss, and reset during a switch.
module tb_eth_tx_clk_ctrl;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   eth_tx_clk_ctrl_if bus ();

   eth_tx_clk_ctrl dut (
      .rx_clk125 (clk),
      .reset_n   (rst_n),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #4 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_clk(input string tag, input logic exp_tx, input logic exp_rise);
      chk({tag, "_tx"}, {7'd0, bus.tx_clk}, {7'd0, exp_tx});
      chk({tag, "_rise"}, {7'd0, bus.tx_clk_rise}, {7'd0, exp_rise});
   endtask

   task automatic chk_idle(input string tag, input logic [1:0] exp_cur, input logic exp_gmii);
      chk({tag, "_ack"}, {7'd0, bus.speed_ack}, 8'd0);
      chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
      chk({tag, "_cur"}, {6'd0, bus.cur_speed}, {6'd0, exp_cur});
      chk({tag, "_gmii"}, {7'd0, bus.gmii_sel}, {7'd0, exp_gmii});
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.link_up         = 1'b1;
      bus.speed_req       = 2'b00;
      bus.speed_req_valid = 1'b0;

      // Reset state
      repeat (3) tick();
      chk_clk("rst", 1'b0, 1'b0);
      chk_idle("rst", 2'b00, 1'b0);
      chk("rst_err", {7'd0, bus.speed_err}, 8'd0);
      rst_n = 1'b1;

      // 1: 10M, 25 high / 25 low, rise with each 0->1
      for (int k = 1; k <= 110; k++) begin
         tick();
         chk_clk("t1", ((k - 1) % 50) < 25, ((k - 1) % 50) == 0);
         chk_idle("t1", 2'b00, 1'b0);
      end

      // 2: 10M -> 100M requested with counter at 10 (mid high phase)
      bus.speed_req       = 2'b01;
      bus.speed_req_valid = 1'b1;
      for (int d = 1; d <= 48; d++) begin
         tick();
         chk("t2_tx", {7'd0, bus.tx_clk},
             (d <= 40) ? {7'd0, (((109 + d) % 50) < 25)} : 8'd0);
         chk("t2_busy", {7'd0, bus.busy}, 8'd1);
         chk("t2_ack", {7'd0, bus.speed_ack}, 8'd0);
         chk("t2_gmii", {7'd0, bus.gmii_sel}, 8'd0);
      end
      tick();
      chk("t2_ack1", {7'd0, bus.speed_ack}, 8'd1);
      chk("t2_err", {7'd0, bus.speed_err}, 8'd0);
      chk("t2_cur", {6'd0, bus.cur_speed}, 8'd1);
      chk("t2_busy0", {7'd0, bus.busy}, 8'd0);
      chk_clk("t2_ackclk", 1'b0, 1'b0);
      bus.speed_req_valid = 1'b0;
      for (int j = 0; j <= 9; j++) begin
         tick();
         chk_clk("t2_100m", (j % 5) < 2, (j % 5) == 0);
         chk_idle("t2_100m", 2'b01, 1'b0);
      end

      // 4: illegal request, then same-speed request held for two cycles
      bus.speed_req       = 2'b11;
      bus.speed_req_valid = 1'b1;
      tick();
      chk("t4_ill_ack", {7'd0, bus.speed_ack}, 8'd1);
      chk("t4_ill_err", {7'd0, bus.speed_err}, 8'd1);
      chk("t4_ill_cur", {6'd0, bus.cur_speed}, 8'd1);
      chk("t4_ill_busy", {7'd0, bus.busy}, 8'd0);
      chk_clk("t4_ill", 1'b1, 1'b1);
      bus.speed_req_valid = 1'b0;
      for (int j = 11; j <= 13; j++) begin
         tick();
         chk_clk("t4_a", (j % 5) < 2, (j % 5) == 0);
         chk_idle("t4_a", 2'b01, 1'b0);
      end
      bus.speed_req       = 2'b01;
      bus.speed_req_valid = 1'b1;
      tick();
      chk("t4_same_ack", {7'd0, bus.speed_ack}, 8'd1);
      chk("t4_same_err", {7'd0, bus.speed_err}, 8'd0);
      chk_clk("t4_same", 1'b0, 1'b0);
      tick();
      chk("t4_single_pulse", {7'd0, bus.speed_ack}, 8'd0);
      chk_clk("t4_hold", 1'b1, 1'b1);
      bus.speed_req_valid = 1'b0;
      for (int j = 16; j <= 20; j++) begin
         tick();
         chk_clk("t4_b", (j % 5) < 2, (j % 5) == 0);
         chk_idle("t4_b", 2'b01, 1'b0);
      end

      // 5: link loss during the high phase at 100M
      bus.link_up = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         tick();
         chk_clk("t5_down", 1'b0, 1'b0);
      end
      bus.link_up = 1'b1;
      for (int m = 1; m <= 10; m++) begin
         tick();
         chk_clk("t5_up", ((m - 1) % 5) < 2, ((m - 1) % 5) == 0);
         chk_idle("t5_up", 2'b01, 1'b0);
      end

      // 3a: 100M -> 1000M
      bus.speed_req       = 2'b10;
      bus.speed_req_valid = 1'b1;
      for (int d = 1; d <= 13; d++) begin
         tick();
         chk_clk("t3_drain", d <= 2, d == 1);
         chk("t3_busy", {7'd0, bus.busy}, 8'd1);
         chk("t3_ack0", {7'd0, bus.speed_ack}, 8'd0);
         chk("t3_gmii0", {7'd0, bus.gmii_sel}, 8'd0);
      end
      tick();
      chk("t3_ack", {7'd0, bus.speed_ack}, 8'd1);
      chk("t3_err", {7'd0, bus.speed_err}, 8'd0);
      chk("t3_cur", {6'd0, bus.cur_speed}, 8'd2);
      chk("t3_gmii", {7'd0, bus.gmii_sel}, 8'd1);
      bus.speed_req_valid = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk_clk("t3_1g", 1'b0, 1'b1);
         chk_idle("t3_1g", 2'b10, 1'b1);
      end

      // 3b: 1000M -> 10M, hold entered right after acceptance
      bus.speed_req       = 2'b00;
      bus.speed_req_valid = 1'b1;
      tick();
      chk("t3b_busy", {7'd0, bus.busy}, 8'd1);
      chk("t3b_gmii", {7'd0, bus.gmii_sel}, 8'd1);
      chk_clk("t3b_acc", 1'b0, 1'b1);
      for (int f = 2; f <= 10; f++) begin
         tick();
         chk("t3b_busy_h", {7'd0, bus.busy}, 8'd1);
         chk("t3b_gmii_h", {7'd0, bus.gmii_sel}, 8'd0);
         chk("t3b_ack0", {7'd0, bus.speed_ack}, 8'd0);
         chk_clk("t3b_hold", 1'b0, 1'b0);
      end
      tick();
      chk("t3b_ack", {7'd0, bus.speed_ack}, 8'd1);
      chk("t3b_err", {7'd0, bus.speed_err}, 8'd0);
      chk("t3b_cur", {6'd0, bus.cur_speed}, 8'd0);
      chk_clk("t3b_ackclk", 1'b0, 1'b0);
      bus.speed_req_valid = 1'b0;
      for (int g = 1; g <= 60; g++) begin
         tick();
         chk_clk("t3b_10m", ((g - 1) % 50) < 25, ((g - 1) % 50) == 0);
         chk_idle("t3b_10m", 2'b00, 1'b0);
      end

      // 6: reset during HOLD of a 10M -> 100M switch
      bus.speed_req       = 2'b01;
      bus.speed_req_valid = 1'b1;
      for (int h = 1; h <= 44; h++) begin
         tick();
         chk("t6_tx", {7'd0, bus.tx_clk},
             (h <= 40) ? {7'd0, (((9 + h) % 50) < 25)} : 8'd0);
         chk("t6_busy", {7'd0, bus.busy}, 8'd1);
      end
      rst_n               = 1'b0;
      bus.speed_req_valid = 1'b0;
      #1;
      chk_clk("t6_rst", 1'b0, 1'b0);
      chk_idle("t6_rst", 2'b00, 1'b0);
      repeat (3) begin
         tick();
         chk("t6_rst_ack", {7'd0, bus.speed_ack}, 8'd0);
         chk("t6_rst_busy", {7'd0, bus.busy}, 8'd0);
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 55; n++) begin
         tick();
         chk_clk("t6_10m", ((n - 1) % 50) < 25, ((n - 1) % 50) == 0);
         chk_idle("t6_10m", 2'b00, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/eth_tx_clk_ctrl.md
Name: eth_tx_clk_ctrl

Overview:
Speed-aware controller for the Ethernet TX clock path, running entirely in the 125 MHz receive clock domain. It generates the MII/GMII TX clock for 10, 100 and 1000 Mbps. It accepts speed-change requests from the MAC/management logic, and it sequences glitch-free switching: drain to a low phase, hold low, reload the divider, acknowledge. It replaces the fixed divider feeding the PHY TX clock pin.

Parameters:
DIV_10M, 50, divider period in rx_clk125 cycles for 10 Mbps (2.5 MHz)
HIGH_10M, 25, cycles tx_clk is high per 10 Mbps period
DIV_100M, 5, divider period for 100 Mbps (25 MHz)
HIGH_100M, 2, cycles tx_clk is high per 100 Mbps period
HOLD_CYCLES, 8, cycles tx_clk is forced low between speeds (1..63)
RESET_SPEED, 2'b00, speed code loaded at reset

Ports:
rx_clk125  in  1  125 MHz clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
link_up  in  1  PHY link status; 0 gates tx_clk low
speed_req  in  2  requested speed: 00=10M, 01=100M, 10=1000M, 11=illegal
speed_req_valid  in  1  level request; held until speed_ack
speed_ack  out  1  one-cycle pulse, request completed
speed_err  out  1  valid only with speed_ack; 1 = request rejected
cur_speed  out  2  speed currently generated
gmii_sel  out  1  1 when cur_speed=10 (external mux selects raw 125 MHz)
tx_clk  out  1  registered divided clock (10M/100M); 0 in 1000M
tx_clk_rise  out  1  high in the cycle tx_clk goes 0->1; constant 1 in 1000M when running
busy  out  1  high in DRAIN/HOLD/LOAD

Behaviour:
- Reset values: tx_clk=0, tx_clk_rise=0, speed_ack=0, speed_err=0, busy=0, cur_speed=RESET_SPEED, gmii_sel=(RESET_SPEED==10), counter=0, state=RUN.
- Counter is 6 bits. In RUN with link_up=1:
  - counter wraps from DIV-1 to 0.
  - tx_clk <= (counter < HIGH), registered, so it lags the counter by one cycle. Pattern for 100M: counter 0 1 2 3 4 gives tx_clk 1 1 0 0 0.
  - tx_clk_rise = registered (counter==0).
- link_up=0: counter held 0, tx_clk=0, tx_clk_rise=0. Requests are still serviced. Counting resumes from 0 on the first cycle link_up=1, so the first high phase is complete.
- FSM states: RUN, DRAIN, HOLD, LOAD.
- RUN: a request is accepted when speed_req_valid=1 and busy=0.
  - speed_req==11: speed_ack=1 and speed_err=1 next cycle; no state change.
  - speed_req==cur_speed: speed_ack=1 and speed_err=0 next cycle; no disturbance to tx_clk.
  - Otherwise latch speed_req and go to DRAIN; busy=1.
- DRAIN: counter keeps running until tx_clk=0 and counter==DIV-1 (end of low phase), then go to HOLD.
  - From 1000M or link_up=0, go to HOLD immediately next cycle.
  - A high phase is never truncated.
- HOLD: tx_clk=0, tx_clk_rise=0, gmii_sel=0. A hold counter runs for HOLD_CYCLES cycles, then go to LOAD.
- LOAD (1 cycle): cur_speed <= latched speed, gmii_sel updated, counter <= 0, speed_ack=1, speed_err=0, next state RUN. busy drops the cycle after LOAD.
- Handshake: speed_ack is a single-cycle pulse. A requester holding speed_req_valid after the ack is seen as a new request, two cycles after ack at the earliest. speed_req changes while busy are ignored; the value latched at acceptance wins.
- Acceptance latency: same-speed or illegal requests ack 1 cycle after valid is sampled.
- Asynchronous reset mid-switch returns to RESET_SPEED, RUN, with no ack.
- gmii_sel never changes while tx_clk=1. Every speed change includes at least HOLD_CYCLES of both gmii_sel=0 and tx_clk=0.

Test Plan:
1. Reset with RESET_SPEED=00, link_up=1 -> tx_clk period 50 cycles, 25 high / 25 low; tx_clk_rise every 50th cycle, coincident with tx_clk 0->1.
2. Request 01 at an arbitrary 10M phase -> tx_clk completes its current high phase and low phase; then 8 low cycles with gmii_sel=0; speed_ack pulses once with speed_err=0; cur_speed=01; then pattern 1 1 0 0 0 repeats.
3. Request 10 from 100M -> drain, 8-cycle hold, ack; gmii_sel=1, tx_clk=0, tx_clk_rise=1 constantly. Then request 00 -> HOLD entered next cycle, gmii_sel=0 for 8 cycles, 2.5 MHz resumes.
4. Request 11 and, separately, request equal to cur_speed -> ack next cycle with speed_err=1 and 0 respectively; tx_clk waveform is bit-identical to the no-request run.
5. link_up=0 for 20 cycles mid-high-phase at 100M -> tx_clk low within 1 cycle; on link_up=1, the first tx_clk high phase lasts the full 2 cycles.
6. Assert reset_n=0 during HOLD of a 00->01 switch -> outputs take their reset values immediately; no speed_ack; after release, 10M generation starts from counter=0.
